// File: rtl/data_mem_lsu.sv
// Byte-addressed data memory with an integrated load/store unit.
// It accepts one request at a time through a valid/ready handshake and
// performs the array access a fixed number of cycles after acceptance.
// It then returns a single-cycle response carrying the extended load data
// or an error flag for misaligned, reserved-size or out-of-range requests.
module data_mem_lsu #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int CW = $clog2(LATENCY) + 1;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [IW:0] DEPTH_LIM = (IW + 1)'(DEPTH);

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_reg;
  logic [CW-1:0]         cnt_reg;
  logic                  write_reg;
  logic [1:0]            size_reg;
  logic                  uns_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]           wdata_reg;
  logic                  resp_valid_reg;
  logic [31:0]           resp_rdata_reg;
  logic                  resp_err_reg;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          access;
  logic [IW-1:0] word_idx;
  logic [1:0]    lane;
  logic [MW-1:0] mem_idx;
  logic          req_err;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;

  assign req_ready = (state_reg == IDLE) || (state_reg == RESP);
  assign accept    = req_valid && req_ready;
  assign access    = (state_reg == BUSY) && (cnt_reg == '0);
  assign word_idx  = addr_reg[ADDR_WIDTH-1:2];
  assign lane      = addr_reg[1:0];
  assign mem_idx   = MW'(word_idx);
  assign we        = access && write_reg && !req_err;
  assign rd_word   = mem[mem_idx];

  // Error detection, lane enables and load extraction from the latched request
  always_comb begin
    req_err   = 1'b0;
    be        = 4'b0000;
    wlane     = 32'd0;
    rd_byte   = rd_word[{lane, 3'b000} +: 8];
    rd_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    if (size_reg == 2'b11)                  req_err = 1'b1;
    if (size_reg == SIZE_H && lane[0])      req_err = 1'b1;
    if (size_reg == SIZE_W && lane != 2'b00) req_err = 1'b1;
    if ({1'b0, word_idx} >= DEPTH_LIM)      req_err = 1'b1;
    case (size_reg)
      SIZE_B: begin
        be        = 4'b0001 << lane;
        wlane     = {4{wdata_reg[7:0]}};
        load_data = uns_reg ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      end
      SIZE_H: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wlane     = {2{wdata_reg[15:0]}};
        load_data = uns_reg ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      end
      default: begin
        be        = 4'b1111;
        wlane     = wdata_reg;
        load_data = rd_word;
      end
    endcase
  end

  // Byte-enabled array write at the access edge; unselected lanes keep their contents
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[mem_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // Handshake FSM: latch request, count down latency, emit one response pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      write_reg      <= 1'b0;
      size_reg       <= 2'b00;
      uns_reg        <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= 32'd0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= 32'd0;
      resp_err_reg   <= 1'b0;
    end else begin
      resp_valid_reg <= 1'b0;
      case (state_reg)
        BUSY: begin
          if (cnt_reg == '0) begin
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= req_err;
            resp_rdata_reg <= (req_err || write_reg) ? 32'd0 : load_data;
            state_reg      <= RESP;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: begin
          // IDLE and RESP both accept; RESP falls back to IDLE when nothing arrives
          if (accept) begin
            write_reg <= req_write;
            size_reg  <= req_size;
            uns_reg   <= req_unsigned;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            cnt_reg   <= CW'(LATENCY - 1);
            state_reg <= BUSY;
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

endmodule
